// File: rtl/seq_packet_serializer_pkg.sv
// Shared widths, lane record and helpers for the sequence packet serializer.
// Widths mirror the sequence-bus width set; SEQ_PACKET_IDX_BITS indexes a lane.
package seq_packet_serializer_pkg;

    localparam int SEQ_PACKET_SIZE     = 4;
    localparam int SEQ_LL_BITS         = 8;
    localparam int SEQ_ML_BITS         = 8;
    localparam int SEQ_OFFSET_BITS     = 16;
    localparam int SEQ_PACKET_IDX_BITS = $clog2(SEQ_PACKET_SIZE);
    // Trim arithmetic width: one bit above the wider of ll/ml so nothing wraps.
    localparam int SEQ_CMP_BITS        = ((SEQ_LL_BITS > SEQ_ML_BITS) ? SEQ_LL_BITS : SEQ_ML_BITS) + 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_EMIT  = 1'b1
    } ser_state_t;

    typedef struct packed {
        logic [SEQ_LL_BITS-1:0]     ll;
        logic [SEQ_ML_BITS-1:0]     ml;
        logic [SEQ_OFFSET_BITS-1:0] offset;
    } seq_lane_t;

    function automatic logic [SEQ_PACKET_IDX_BITS-1:0] lowest_lane(input logic [SEQ_PACKET_SIZE-1:0] m);
        logic [SEQ_PACKET_IDX_BITS-1:0] idx;
        idx = '0;
        for (int i = SEQ_PACKET_SIZE - 1; i >= 0; i--)
            if (m[i]) idx = SEQ_PACKET_IDX_BITS'(i);
        return idx;
    endfunction

endpackage

// File: rtl/seq_overlap_trim.sv
// Removes up to `carry` leading bytes from one sequence: literals first, then match.
// A lane whose bytes are all covered is dropped and the remainder carried on.
module seq_overlap_trim
    import seq_packet_serializer_pkg::*;
(
    input  logic [SEQ_LL_BITS-1:0] i_ll,
    input  logic [SEQ_ML_BITS-1:0] i_ml,
    input  logic [SEQ_ML_BITS:0]   i_carry,
    output logic [SEQ_LL_BITS-1:0] o_ll,
    output logic [SEQ_ML_BITS-1:0] o_ml,
    output logic [SEQ_ML_BITS:0]   o_carry,
    output logic                   o_drop
);

    logic [SEQ_CMP_BITS-1:0] w_ll;
    logic [SEQ_CMP_BITS-1:0] w_ml;
    logic [SEQ_CMP_BITS-1:0] w_c;
    logic [SEQ_CMP_BITS-1:0] w_r;

    assign w_ll = SEQ_CMP_BITS'(i_ll);
    assign w_ml = SEQ_CMP_BITS'(i_ml);
    assign w_c  = SEQ_CMP_BITS'(i_carry);

    always_comb begin
        o_ll    = i_ll;
        o_ml    = i_ml;
        o_carry = '0;
        o_drop  = 1'b0;
        w_r     = '0;
        if (w_c != '0) begin
            if (w_ll >= w_c) begin
                o_ll = SEQ_LL_BITS'(w_ll - w_c);
            end else begin
                w_r  = w_c - w_ll;
                o_ll = '0;
                if (w_ml > w_r) begin
                    o_ml = SEQ_ML_BITS'(w_ml - w_r);
                end else begin
                    o_drop  = 1'b1;
                    o_carry = (SEQ_ML_BITS+1)'(w_r - w_ml);
                end
            end
        end
    end

endmodule

// File: rtl/seq_packet_serializer.sv
// Accepts one sequence packet and emits its lanes one per cycle, oldest first.
// Define SEQ_SERIALIZER_STATS_EN to add the handshake/trim counter ports.
module seq_packet_serializer
    import seq_packet_serializer_pkg::*;
(
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       i_valid,
    input  logic [SEQ_PACKET_SIZE-1:0]                 i_mask,
    input  logic [SEQ_LL_BITS*SEQ_PACKET_SIZE-1:0]     i_ll,
    input  logic [SEQ_ML_BITS*SEQ_PACKET_SIZE-1:0]     i_ml,
    input  logic [SEQ_OFFSET_BITS*SEQ_PACKET_SIZE-1:0] i_offset,
    input  logic [SEQ_ML_BITS-1:0]                     i_overlap,
    input  logic                                       i_eoj,
    input  logic                                       i_delim,
    output logic                                       i_ready,
    output logic                                       o_seq_valid,
    output logic [SEQ_LL_BITS-1:0]                     o_seq_ll,
    output logic [SEQ_ML_BITS-1:0]                     o_seq_ml,
    output logic [SEQ_OFFSET_BITS-1:0]                 o_seq_offset,
    output logic                                       o_seq_eoj,
    output logic                                       o_seq_delim,
    input  logic                                       o_seq_ready
`ifdef SEQ_SERIALIZER_STATS_EN
    ,
    output logic [31:0]                                o_stat_seq_cnt,
    output logic [31:0]                                o_stat_trim_cnt
`endif
);

    ser_state_t                     r_state, w_state_next;
    seq_lane_t                      r_lane [SEQ_PACKET_SIZE];
    seq_lane_t                      w_in_lane [SEQ_PACKET_SIZE];
    seq_lane_t                      w_cur;
    logic [SEQ_PACKET_SIZE-1:0]     r_rem, w_src_mask, w_rem_next;
    logic [SEQ_ML_BITS:0]           r_carry, w_src_carry, w_trim_carry;
    logic                           r_eoj, r_delim, w_src_eoj, w_src_delim;
    logic [SEQ_PACKET_IDX_BITS-1:0] w_idx;
    logic [SEQ_LL_BITS-1:0]         w_trim_ll;
    logic [SEQ_ML_BITS-1:0]         w_trim_ml;
    logic                           w_drop;
    logic                           w_adv, w_fin_hs, w_accept, w_from_hold, w_proc;
    logic                           w_empty, w_last, w_lane_ok, w_marker, w_beat;
    logic                           r_ov, r_oeoj, r_odelim;
    logic [SEQ_LL_BITS-1:0]         r_oll;
    logic [SEQ_ML_BITS-1:0]         r_oml;
    logic [SEQ_OFFSET_BITS-1:0]     r_ooff;

    for (genvar g = 0; g < SEQ_PACKET_SIZE; g++) begin : g_lane
        assign w_in_lane[g].ll     = i_ll[g*SEQ_LL_BITS +: SEQ_LL_BITS];
        assign w_in_lane[g].ml     = i_ml[g*SEQ_ML_BITS +: SEQ_ML_BITS];
        assign w_in_lane[g].offset = i_offset[g*SEQ_OFFSET_BITS +: SEQ_OFFSET_BITS];
    end

    // While EMIT with rem==0 the output register holds the packet's final beat.
    assign w_adv       = !r_ov || o_seq_ready;
    assign w_fin_hs    = (r_state == ST_EMIT) && (r_rem == '0) && r_ov && o_seq_ready;
    assign i_ready     = rst_n && ((r_state == ST_EMPTY) || w_fin_hs);
    assign w_accept    = i_valid && i_ready;
    assign w_from_hold = (r_state == ST_EMIT) && (r_rem != '0);
    assign w_proc      = w_adv && (w_from_hold || w_accept);

    // A freshly accepted packet is processed straight from the inputs so its first beat lands next cycle.
    assign w_src_mask  = w_from_hold ? r_rem   : i_mask;
    assign w_src_carry = w_from_hold ? r_carry : {1'b0, i_overlap};
    assign w_src_eoj   = w_from_hold ? r_eoj   : i_eoj;
    assign w_src_delim = w_from_hold ? r_delim : i_delim;
    assign w_idx       = lowest_lane(w_src_mask);
    assign w_cur       = w_from_hold ? r_lane[w_idx] : w_in_lane[w_idx];

    seq_overlap_trim u_trim (
        .i_ll    (w_cur.ll),
        .i_ml    (w_cur.ml),
        .i_carry (w_src_carry),
        .o_ll    (w_trim_ll),
        .o_ml    (w_trim_ml),
        .o_carry (w_trim_carry),
        .o_drop  (w_drop)
    );

    assign w_empty    = (w_src_mask == '0);
    assign w_rem_next = w_src_mask & ~(SEQ_PACKET_SIZE'(1) << w_idx);
    assign w_last     = (w_rem_next == '0);
    assign w_lane_ok  = !w_empty && !w_drop;
    assign w_marker   = w_last && !w_lane_ok && (w_src_eoj || w_src_delim);
    assign w_beat     = w_lane_ok || w_marker;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_EMPTY;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_proc)
            w_state_next = (w_beat || !w_last) ? ST_EMIT : ST_EMPTY;
        else if (w_fin_hs)
            w_state_next = ST_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (w_accept && w_adv)
            for (int k = 0; k < SEQ_PACKET_SIZE; k++) r_lane[k] <= w_in_lane[k];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem    <= '0;
            r_carry  <= '0;
            r_eoj    <= 1'b0;
            r_delim  <= 1'b0;
            r_ov     <= 1'b0;
            r_oll    <= '0;
            r_oml    <= '0;
            r_ooff   <= '0;
            r_oeoj   <= 1'b0;
            r_odelim <= 1'b0;
        end else if (w_proc) begin
            if (w_accept) begin
                r_eoj   <= i_eoj;
                r_delim <= i_delim;
            end
            r_rem    <= w_rem_next;
            r_carry  <= w_trim_carry;
            r_ov     <= w_beat;
            r_oll    <= w_lane_ok ? w_trim_ll    : '0;
            r_oml    <= w_lane_ok ? w_trim_ml    : '0;
            r_ooff   <= w_lane_ok ? w_cur.offset : '0;
            r_oeoj   <= w_beat && w_last && w_src_eoj;
            r_odelim <= w_beat && w_last && w_src_delim;
        end else if (w_adv) begin
            r_ov     <= 1'b0;
            r_oeoj   <= 1'b0;
            r_odelim <= 1'b0;
        end
    end

    assign o_seq_valid  = r_ov;
    assign o_seq_ll     = r_oll;
    assign o_seq_ml     = r_oml;
    assign o_seq_offset = r_ooff;
    assign o_seq_eoj    = r_oeoj;
    assign o_seq_delim  = r_odelim;

`ifdef SEQ_SERIALIZER_STATS_EN
    logic [31:0] r_stat_seq, r_stat_trim;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_seq  <= '0;
            r_stat_trim <= '0;
        end else begin
            if (r_ov && o_seq_ready)
                r_stat_seq <= r_stat_seq + 32'd1;
            if (w_proc && !w_empty && (w_src_carry != '0))
                r_stat_trim <= r_stat_trim + 32'd1;
        end
    end

    assign o_stat_seq_cnt  = r_stat_seq;
    assign o_stat_trim_cnt = r_stat_trim;
`endif

endmodule

// File: tb/tb_seq_packet_serializer.sv
// Directed and randomized bench for seq_packet_serializer against a packet-level reference model.
module tb_seq_packet_serializer;
    import seq_packet_serializer_pkg::*;

    localparam int N    = SEQ_PACKET_SIZE;
    localparam int LLB  = SEQ_LL_BITS;
    localparam int MLB  = SEQ_ML_BITS;
    localparam int OFB  = SEQ_OFFSET_BITS;
    localparam int NPKT = 400;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 i_valid;
    logic [N-1:0]         i_mask;
    logic [LLB*N-1:0]     i_ll;
    logic [MLB*N-1:0]     i_ml;
    logic [OFB*N-1:0]     i_offset;
    logic [MLB-1:0]       i_overlap;
    logic                 i_eoj, i_delim, i_ready;
    logic                 o_seq_valid;
    logic [LLB-1:0]       o_seq_ll;
    logic [MLB-1:0]       o_seq_ml;
    logic [OFB-1:0]       o_seq_offset;
    logic                 o_seq_eoj, o_seq_delim, o_seq_ready;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    seq_packet_serializer dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_mask(i_mask),
        .i_ll(i_ll), .i_ml(i_ml), .i_offset(i_offset), .i_overlap(i_overlap),
        .i_eoj(i_eoj), .i_delim(i_delim), .i_ready(i_ready),
        .o_seq_valid(o_seq_valid), .o_seq_ll(o_seq_ll), .o_seq_ml(o_seq_ml),
        .o_seq_offset(o_seq_offset), .o_seq_eoj(o_seq_eoj), .o_seq_delim(o_seq_delim),
        .o_seq_ready(o_seq_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int ll, input int ml, input int off, input logic e, input logic d);
        return 64'({LLB'(ll), MLB'(ml), OFB'(off), e, d});
    endfunction

    function automatic logic [63:0] obs();
        return pack(int'(o_seq_ll), int'(o_seq_ml), int'(o_seq_offset), o_seq_eoj, o_seq_delim);
    endfunction

    task automatic clear_pkt();
        i_valid = 1'b0; i_mask = '0; i_ll = '0; i_ml = '0; i_offset = '0;
        i_overlap = '0; i_eoj = 1'b0; i_delim = 1'b0;
    endtask

    task automatic set_lane(input int k, input int ll, input int ml, input int off);
        i_ll[k*LLB +: LLB]     = LLB'(ll);
        i_ml[k*MLB +: MLB]     = MLB'(ml);
        i_offset[k*OFB +: OFB] = OFB'(off);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic gen_pkt();
        i_mask = N'($urandom_range(0, (1 << N) - 1));
        for (int k = 0; k < N; k++)
            set_lane(k, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12)),
                        ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12)),
                        int'($urandom_range(0, 65535)));
        i_overlap = ($urandom_range(0, 2) == 0) ? MLB'($urandom_range(1, 40)) : '0;
        i_eoj     = ($urandom_range(0, 3) == 0);
        i_delim   = ($urandom_range(0, 3) == 0);
    endtask

    // Expected beats of the packet currently on the inputs, in emission order.
    task automatic model_pkt();
        int          carry, l, m, r;
        logic        drop;
        logic [63:0] q[$];
        logic [63:0] tmp;
        carry = int'(i_overlap);
        for (int k = 0; k < N; k++) begin
            if (i_mask[k]) begin
                l    = int'(i_ll[k*LLB +: LLB]);
                m    = int'(i_ml[k*MLB +: MLB]);
                drop = 1'b0;
                if (carry > 0) begin
                    if (l >= carry) begin
                        l = l - carry; carry = 0;
                    end else begin
                        r = carry - l; l = 0;
                        if (m > r) begin m = m - r; carry = 0; end
                        else begin drop = 1'b1; carry = r - m; end
                    end
                end
                if (!drop) q.push_back(pack(l, m, int'(i_offset[k*OFB +: OFB]), 1'b0, 1'b0));
            end
        end
        if (q.size() == 0) begin
            if (i_eoj || i_delim) q.push_back(pack(0, 0, 0, i_eoj, i_delim));
        end else begin
            tmp = q.pop_back();
            tmp[1:0] = {i_eoj, i_delim};
            q.push_back(tmp);
        end
        foreach (q[j]) exp_q.push_back(q[j]);
    endtask

    initial begin
        int          npk, cyc;
        logic        pend, hold_prev;
        logic [63:0] prev, want;

        rst_n = 1'b0; o_seq_ready = 1'b0; clear_pkt();
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", i_ready, 1'b0);
        check("rst_valid", o_seq_valid, 1'b0);
        check("rst_fields", obs(), pack(0, 0, 0, 1'b0, 1'b0));
        rst_n = 1'b1; o_seq_ready = 1'b1;
        #1;
        check("idle_ready", i_ready, 1'b1);

        // Mask 1011, eoj: three beats, eoj and i_ready only on the last.
        clear_pkt(); i_mask = 4'b1011; i_eoj = 1'b1; i_valid = 1'b1;
        for (int k = 0; k < N; k++) set_lane(k, k + 1, 10 + k, 100 + k);
        step(); i_valid = 1'b0;
        check("t1_v0", o_seq_valid, 1'b1);
        check("t1_b0", obs(), pack(1, 10, 100, 1'b0, 1'b0));
        check("t1_rdy0", i_ready, 1'b0);
        step();
        check("t1_b1", obs(), pack(2, 11, 101, 1'b0, 1'b0));
        check("t1_rdy1", i_ready, 1'b0);
        step();
        check("t1_v2", o_seq_valid, 1'b1);
        check("t1_b2", obs(), pack(4, 13, 103, 1'b1, 1'b0));
        check("t1_rdy2", i_ready, 1'b1);
        step();
        check("t1_end", o_seq_valid, 1'b0);

        // Overlap 5 into ll=2 ml=4.
        clear_pkt(); i_mask = 4'b0001; i_overlap = 8'd5; set_lane(0, 2, 4, 7); i_valid = 1'b1;
        step(); i_valid = 1'b0;
        check("t2_v", o_seq_valid, 1'b1);
        check("t2_b", obs(), pack(0, 1, 7, 1'b0, 1'b0));
        step();
        check("t2_end", o_seq_valid, 1'b0);

        // Overlap 10: lane0 dropped, lane1 trimmed.
        clear_pkt(); i_mask = 4'b0011; i_overlap = 8'd10;
        set_lane(0, 2, 4, 1); set_lane(1, 3, 6, 2); i_valid = 1'b1;
        step(); i_valid = 1'b0;
        check("t3_bubble", o_seq_valid, 1'b0);
        check("t3_bub_rdy", i_ready, 1'b0);
        step();
        check("t3_v", o_seq_valid, 1'b1);
        check("t3_b", obs(), pack(0, 5, 2, 1'b0, 1'b0));
        step();
        check("t3_end", o_seq_valid, 1'b0);

        // Empty packets: delim marker beat, then a silent one.
        clear_pkt(); i_delim = 1'b1; set_lane(0, 9, 9, 9); set_lane(2, 5, 5, 5); i_valid = 1'b1;
        step(); i_valid = 1'b0;
        check("t4_v", o_seq_valid, 1'b1);
        check("t4_b", obs(), pack(0, 0, 0, 1'b0, 1'b1));
        check("t4_rdy", i_ready, 1'b1);
        step();
        check("t4_end", o_seq_valid, 1'b0);
        clear_pkt(); i_valid = 1'b1;
        step(); i_valid = 1'b0;
        check("t4s_v", o_seq_valid, 1'b0);
        check("t4s_rdy", i_ready, 1'b1);

        // Three-cycle stall on the second beat.
        clear_pkt(); i_mask = 4'b1111; i_delim = 1'b1; i_valid = 1'b1;
        for (int k = 0; k < N; k++) set_lane(k, 5 + k, 20 + k, 300 + k);
        step(); i_valid = 1'b0;
        check("t5_b0", obs(), pack(5, 20, 300, 1'b0, 1'b0));
        step(); o_seq_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check("t5_stall_v", o_seq_valid, 1'b1);
            check("t5_stall_b", obs(), pack(6, 21, 301, 1'b0, 1'b0));
            check("t5_stall_rdy", i_ready, 1'b0);
            step();
        end
        o_seq_ready = 1'b1;
        check("t5_b1", obs(), pack(6, 21, 301, 1'b0, 1'b0));
        step();
        check("t5_b2", obs(), pack(7, 22, 302, 1'b0, 1'b0));
        step();
        check("t5_b3", obs(), pack(8, 23, 303, 1'b0, 1'b1));
        step();
        check("t5_end", o_seq_valid, 1'b0);

        // Reset during the second beat of a 4-lane packet.
        clear_pkt(); i_mask = 4'b1111; i_valid = 1'b1;
        for (int k = 0; k < N; k++) set_lane(k, 20 + k, 1, k);
        step(); i_valid = 1'b0;
        step();
        check("t6_b1", obs(), pack(21, 1, 1, 1'b0, 1'b0));
        rst_n = 1'b0;
        step();
        check("t6_rst_v", o_seq_valid, 1'b0);
        check("t6_rst_rdy", i_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        check("t6_held0", i_ready, 1'b1);
        clear_pkt(); i_mask = 4'b0001; set_lane(0, 9, 3, 5); i_valid = 1'b1;
        step(); i_valid = 1'b0;
        check("t6_new_v", o_seq_valid, 1'b1);
        check("t6_new_b", obs(), pack(9, 3, 5, 1'b0, 1'b0));
        step();
        check("t6_new_end", o_seq_valid, 1'b0);

        // Randomized traffic against the reference model.
        clear_pkt(); gen_pkt();
        npk = 0; cyc = 0; pend = 1'b0; hold_prev = 1'b0; prev = '0;
        while ((npk < NPKT || exp_q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                if (npk < NPKT) gen_pkt();
            end
            i_valid     = (npk < NPKT) && ($urandom_range(0, 4) != 0);
            o_seq_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (hold_prev) begin
                check("hold_v", o_seq_valid, 1'b1);
                check("hold_b", obs(), prev);
            end
            if (o_seq_valid && !o_seq_ready) check("stall_rdy", i_ready, 1'b0);
            if (o_seq_valid && o_seq_ready) begin
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
                check("beat", obs(), want);
            end
            if (i_valid && i_ready) begin
                model_pkt();
                npk++;
                pend = 1'b1;
            end
            hold_prev = o_seq_valid && !o_seq_ready;
            prev      = obs();
            cyc++;
        end
        check("pkts", 64'(npk), 64'(NPKT));
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_packet_serializer.md
# seq_packet_serializer

Downstream consumer of the sequence packet bus chain: accepts one packet of up to `SEQ_PACKET_SIZE` sequences from the last bus node's `o_next_*` port and emits the valid lanes one sequence per cycle to the sequence encoder.
- Applies the packet's overlap trim to its leading sequences.
- Marks the job end (eoj) and stream delimiter (delim) on the final beat of the packet.

## Interface
- No module parameters; widths come from `SEQ_PACKET_SIZE`, `SEQ_LL_BITS`, `SEQ_ML_BITS`, `SEQ_OFFSET_BITS` (parameters.vh).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- i_valid  in  1  packet valid.
- i_mask  in  SEQ_PACKET_SIZE  lane valid bits; lane 0 is the oldest.
- i_ll / i_ml / i_offset  in  SEQ_LL_BITS·N / SEQ_ML_BITS·N / SEQ_OFFSET_BITS·N  packed lane fields; lane k is at bits [k·W +: W].
- i_overlap  in  SEQ_ML_BITS  bytes at the head of the packet already covered by the previous job.
- i_eoj  in  1  last packet of the job.
- i_delim  in  1  stream delimiter packet.
- i_ready  out  1  packet accept.
- o_seq_valid  out  1  sequence valid.
- o_seq_ll / o_seq_ml / o_seq_offset  out  SEQ_LL_BITS / SEQ_ML_BITS / SEQ_OFFSET_BITS  sequence fields.
- o_seq_eoj  out  1  asserted on the final beat of an eoj packet.
- o_seq_delim  out  1  asserted on the final beat of a delim packet.
- o_seq_ready  in  1  downstream accept.
- Stats ports (only with `SEQ_SERIALIZER_STATS_EN`): o_stat_seq_cnt out 32; o_stat_trim_cnt out 32.

## Operation
- Holding register stores one packet:
  - fields;
  - remaining mask `rem_mask`;
  - overlap carry `carry` (SEQ_ML_BITS+1 wide);
  - eoj and delim flags;
  - `held` bit.
- States:
  - EMPTY (`held=0`).
  - EMIT (`held=1`). The current lane is the lowest set bit of `rem_mask`.
- Trim, applied to the current lane while `carry>0`:
  - If ll ≥ carry: ll −= carry; carry = 0.
  - Else, with r = carry − ll: ll = 0.
    - If ml > r: ml −= r; carry = 0.
    - Else: the lane is dropped; carry = r − ml.
- Comparisons are done at max(SEQ_LL_BITS, SEQ_ML_BITS)+1 bits. No result wraps.
- A dropped lane:
  - costs one cycle;
  - has o_seq_valid=0;
  - clears its `rem_mask` bit.
- Carry left after the packet's last lane is discarded. Carry never crosses packets.
- Final beat = the lane whose clearing leaves `rem_mask` zero. o_seq_eoj and o_seq_delim are asserted only on it.
- Empty packets:
  - Applies when i_mask == 0, or when all lanes are dropped.
  - If eoj or delim is set: exactly one marker beat is emitted with ll=ml=offset=0 and the flags set.
  - If neither is set: the packet is consumed silently.
- Handshake:
  - i_ready = !held, OR (final beat handshaking this cycle, o_seq_valid && o_seq_ready).
  - This gives back-to-back packets with no bubble.
- o_seq_* are driven from registers. They hold stable while o_seq_valid && !o_seq_ready.
- Reset:
  - held=0; o_seq_valid=0; all o_seq fields 0; eoj=delim=0.
  - i_ready is forced 0 while rst_n=0.
  - Reset mid-packet discards the packet with no output.

## Timing
- Packet accepted at edge N → first o_seq_valid in cycle N+1.
- Throughput is one lane per cycle: emitted or dropped.
- A packet with k valid and undropped lanes and no stall occupies k cycles.
- Stalls (o_seq_ready=0) freeze the holding register and the output registers.
- A new packet is accepted in the same cycle as the previous packet's final handshake. Its first beat follows in the next cycle.

## Configuration
- `SEQ_SERIALIZER_STATS_EN` defined:
  - o_stat_seq_cnt increments on every o_seq handshake.
  - o_stat_trim_cnt increments on every lane that is trimmed or dropped.
  - Both reset to 0 and wrap at 2^32.
- Not defined: the counters and their ports are absent. Data behaviour is identical.

## Structure
- Lane width macros stay in parameters.vh.
- Add `SEQ_PACKET_IDX_BITS` = clog2(SEQ_PACKET_SIZE) to parameters.vh.
- Sub-module `seq_overlap_trim`: combinational; inputs ll, ml, carry; outputs ll', ml', carry', drop.

## Test plan
- Packet mask=4'b1011, ll={1,2,3,4}, overlap=0, eoj=1, ready=1 → beats (ll 1), (ll 2), (ll 4) in cycles N+1..N+3; eoj only on the third beat; i_ready=1 in cycle N+3.
- overlap=5, lane0 ll=2 ml=4 → lane0 emitted as ll=0 ml=1.
- overlap=10, lane0 ll=2 ml=4, lane1 ll=3 ml=6 → lane0 dropped (one bubble); lane1 emitted as ll=0 ml=5.
- i_mask=0, delim=1 → one beat with ll=ml=offset=0 and delim=1. Same packet with delim=0 and eoj=0 → no beat.
- Hold o_seq_ready=0 for 3 cycles mid-packet → outputs stable; no lane lost or duplicated; i_ready=0 throughout.
- rst_n=0 during the second beat of a 4-lane packet → next cycle o_seq_valid=0 and held=0; a following packet is emitted cleanly.
